retrigger_deadtime_ctrl: RTL

//  Per-channel dead-time controller and event scheduler for the 48-channel retrigger bank.

---
 rtl/retrigger_deadtime_ctrl_pkg.sv | 23 ++
 rtl/retrigger_deadtime_ctrl_if.sv | 15 +
 rtl/retrigger_deadtime_ctrl_rr_arbiter.sv | 38 +++
 rtl/retrigger_deadtime_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/retrigger_deadtime_ctrl_pkg.sv
// Shared definitions for the retrigger dead-time controller.
//  - Default channel/counter widths used by the top and the arbiter.
//  - Per-channel state encoding (IDLE / PENDING / DEAD, 2 bits).
//  - rr_wrap: wraps a round-robin search position back into 0..width-1.
package retrigger_deadtime_ctrl_pkg;

    localparam int DEF_WIDTH  = 48;
    localparam int DEF_DT_W   = 8;
    localparam int DEF_IDX_W  = 6;
    localparam int DEF_LOST_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DEAD    = 2'd2
    } chan_state_t;

    // The search offset never exceeds 2*width-1, so one subtraction is enough.
    function automatic int unsigned rr_wrap(input int unsigned pos, input int unsigned width);
        return (pos >= width) ? (pos - width) : pos;
    endfunction

endpackage

// File: rtl/retrigger_deadtime_ctrl_if.sv
// Event stream between the dead-time controller and the trigger/readout logic.
//  evt_valid : event index available (source -> sink)
//  evt_chan  : index of the granted channel (source -> sink)
//  evt_ready : sink accepts the event when valid & ready at posedge (sink -> source)
// master = event source (the controller), slave = event consumer.
interface retrigger_deadtime_ctrl_if #(
    parameter int IDX_W = 6
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_chan;

    modport master (output evt_valid, output evt_chan, input evt_ready);
    modport slave  (input evt_valid, input evt_chan, output evt_ready);
endinterface

// File: rtl/retrigger_deadtime_ctrl_rr_arbiter.sv
// Round-robin arbiter over the PENDING channels.
//  req       in  WIDTH  one bit per channel waiting for a grant
//  en        in  1      output slot can accept a new event this cycle
//  ptr       in  IDX_W  last granted channel; the search starts at ptr+1
//  gnt_valid out 1      a channel was granted (combinational)
//  gnt_idx   out IDX_W  granted channel index (combinational)
// The pointer itself is kept in the parent.
module rr_arbiter
    import retrigger_deadtime_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [WIDTH-1:0] req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest position back to the nearest one, so the
    // requester closest after ptr is the last one written and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_pos     = '0;
        for (int k = WIDTH; k >= 1; k--) begin
            w_pos = IDX_W'(rr_wrap(32'(ptr) + 32'(k), 32'(WIDTH)));
            if (en && req[w_pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/retrigger_deadtime_ctrl.sv
// Per-channel dead-time controller and event scheduler for the retrigger bank.
// Each channel runs IDLE -> PENDING -> DEAD -> IDLE; accepted hits are
// serialised round-robin into one valid/ready channel-index stream.
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  hit          in   WIDTH   synchronised hits; a rising edge is one hit
//  enable_mask  in   WIDTH   1 = channel allowed to fire
//  dead_time    in   DT_W    dead time in cycles, sampled on grant
//  act          out  WIDTH   registered activation mask, 1 = armed
//  evt          if   master  event stream (evt_valid / evt_chan / evt_ready)
//  lost_cnt     out  LOST_W  saturating count of dropped hit edges
//  busy         out  1       any channel PENDING/DEAD or an event is held
module retrigger_deadtime_ctrl
    import retrigger_deadtime_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DT_W   = DEF_DT_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int LOST_W = DEF_LOST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           hit,
    input  logic [WIDTH-1:0]           enable_mask,
    input  logic [DT_W-1:0]            dead_time,
    output logic [WIDTH-1:0]           act,
    retrigger_deadtime_ctrl_if.master  evt,
    output logic [LOST_W-1:0]          lost_cnt,
    output logic                       busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  r_hit_d;
    logic [WIDTH-1:0]  r_act;
    logic              r_evt_valid;
    logic [IDX_W-1:0]  r_evt_chan;
    logic [IDX_W-1:0]  r_ptr;
    logic [LOST_W-1:0] r_lost;
    logic              r_busy;

    logic [WIDTH-1:0]  w_edge;
    logic [WIDTH-1:0]  w_pending;
    logic [WIDTH-1:0]  w_gnt;
    logic [WIDTH-1:0]  w_drop;
    logic [WIDTH-1:0]  w_idle_next;
    logic              w_gnt_en;
    logic              w_gnt_valid;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_evt_valid_next;
    logic [CNT_W-1:0]  w_drop_cnt;
    logic [LOST_W:0]   w_lost_sum;
    logic [LOST_W-1:0] w_lost_next;

    assign w_edge   = hit & ~r_hit_d;
    // A new grant may load on the same edge the held event is consumed.
    assign w_gnt_en = ~r_evt_valid | evt.evt_ready;

    rr_arbiter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (w_pending),
        .en        (w_gnt_en),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            chan_state_t     r_state;
            chan_state_t     w_state_next;
            logic [DT_W-1:0] r_cnt;
            logic [DT_W-1:0] w_cnt_next;

            assign w_pending[gi]   = (r_state == ST_PENDING);
            assign w_gnt[gi]       = w_gnt_valid && (w_gnt_idx == IDX_W'(gi));
            // Any edge seen outside IDLE is lost, including one that coincides
            // with this channel's grant or with its last DEAD cycle.
            assign w_drop[gi]      = w_edge[gi] && (r_state != ST_IDLE);
            assign w_idle_next[gi] = (w_state_next == ST_IDLE);

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_edge[gi] && enable_mask[gi])
                            w_state_next = ST_PENDING;
                    end
                    ST_PENDING: begin
                        // Mask is deliberately not looked at here: an accepted
                        // hit is always emitted.
                        if (w_gnt[gi]) begin
                            if (dead_time == '0) begin
                                w_state_next = ST_IDLE;
                            end else begin
                                w_state_next = ST_DEAD;
                                w_cnt_next   = dead_time;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (r_cnt == DT_W'(1)) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt - DT_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end
        end
    endgenerate

    always_comb begin
        w_drop_cnt = '0;
        for (int k = 0; k < WIDTH; k++)
            w_drop_cnt = w_drop_cnt + CNT_W'(w_drop[k]);
    end

    // One extra bit catches the carry so the count can saturate.
    assign w_lost_sum  = {1'b0, r_lost} + (LOST_W+1)'(w_drop_cnt);
    assign w_lost_next = w_lost_sum[LOST_W] ? '1 : w_lost_sum[LOST_W-1:0];

    assign w_evt_valid_next = w_gnt_en ? w_gnt_valid : r_evt_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_d     <= '0;
            r_act       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_ptr       <= IDX_W'(WIDTH - 1);
            r_lost      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_hit_d     <= hit;
            // Built from next state so act drops on the very edge a hit is taken.
            r_act       <= w_idle_next & enable_mask;
            r_lost      <= w_lost_next;
            r_evt_valid <= w_evt_valid_next;
            if (w_gnt_valid) begin
                r_evt_chan <= w_gnt_idx;
                r_ptr      <= w_gnt_idx;
            end
            r_busy      <= ~&w_idle_next | w_evt_valid_next;
        end
    end

    assign act           = r_act;
    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_chan  = r_evt_chan;
    assign lost_cnt      = r_lost;
    assign busy          = r_busy;

endmodule
